mem_stack_unit: RTL and testbench

Hardware LIFO stack serving the MEM stage of the pipelined MIPS core. It consumes the memory-stage control and data fields (PushM, PopM, MemSrcM, WriteDataM) and keeps an on-chip stack array with a pointer and full/empty status. It returns either the top of stack or the data-memory read word to the MEM/WB boundary as ReadDataM. Overflow and underflow are recorded as sticky error flags.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mem_stack_unit_if.sv | 34 +++
 rtl/mem_stack_unit_stack_ram.sv | 25 ++
 rtl/mem_stack_unit.sv | 106 ++++++++++
 tb/tb_mem_stack_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, stack defaults and the
// MEM-stage stack operation decode.
package mips_pkg;

    localparam int DATA_W      = 32;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        REPLACE = 2'b11
    } stack_op_t;

    function automatic stack_op_t decodeStackOp(input logic pushM, input logic popM);
        return stack_op_t'({pushM, popM});
    endfunction

endpackage

// File: rtl/mem_stack_unit_if.sv
// MEM-stage stack bus: pipeline control/data in, read result and stack status out.
interface mem_stack_unit_if
    import mips_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = DATA_W
);

    localparam int SPW = $clog2(DEPTH) + 1;

    logic             PushM;
    logic             PopM;
    logic             MemSrcM;
    logic [WIDTH-1:0] WriteDataM;
    logic [WIDTH-1:0] DataMemRD;
    logic             ErrClr;
    logic [WIDTH-1:0] ReadDataM;
    logic [SPW-1:0]   SP;
    logic             StackFull;
    logic             StackEmpty;
    logic             StackOvf;
    logic             StackUnf;

    modport master (
        output PushM, PopM, MemSrcM, WriteDataM, DataMemRD, ErrClr,
        input  ReadDataM, SP, StackFull, StackEmpty, StackOvf, StackUnf
    );

    modport slave (
        input  PushM, PopM, MemSrcM, WriteDataM, DataMemRD, ErrClr,
        output ReadDataM, SP, StackFull, StackEmpty, StackOvf, StackUnf
    );

endinterface

// File: rtl/mem_stack_unit_stack_ram.sv
// DEPTH x WIDTH stack storage: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module stack_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stack_unit.sv
// MEM-stage hardware LIFO: pointer, saturation, sticky error flags, push/pop
// bypass and the ReadDataM source mux around a stack_ram array.
module mem_stack_unit
    import mips_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input logic              CLK,
    input logic              reset,
    mem_stack_unit_if.slave  bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    stack_op_t        op;
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   spNext;
    logic             ovf;
    logic             unf;
    logic             ovfSet;
    logic             unfSet;
    logic             full;
    logic             empty;
    logic [AW-1:0]    topIdx;
    logic             ramWe;
    logic [AW-1:0]    ramWaddr;
    logic [WIDTH-1:0] ramRdata;
    logic [WIDTH-1:0] stackView;

    assign op     = decodeStackOp(bus.PushM, bus.PopM);
    assign full   = (sp == SP_FULL);
    assign empty  = (sp == '0);
    assign topIdx = AW'(sp - SPW'(1));

    always_comb begin
        spNext    = sp;
        ovfSet    = 1'b0;
        unfSet    = 1'b0;
        ramWe     = 1'b0;
        ramWaddr  = topIdx;
        stackView = empty ? '0 : ramRdata;
        unique case (op)
            PUSH: begin
                if (full) begin
                    ovfSet = 1'b1;
                end else begin
                    ramWe    = 1'b1;
                    ramWaddr = AW'(sp);
                    spNext   = sp + SPW'(1);
                end
            end
            POP: begin
                if (empty) begin
                    unfSet = 1'b1;
                end else begin
                    spNext = sp - SPW'(1);
                end
            end
            REPLACE: begin
                // Empty stack forwards the pushed word straight through without storing it.
                if (empty) begin
                    stackView = bus.WriteDataM;
                end else begin
                    ramWe = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            sp  <= spNext;
            ovf <= ovfSet | (ovf & ~bus.ErrClr);
            unf <= unfSet | (unf & ~bus.ErrClr);
        end
    end

    // Gating with reset keeps a push in flight during reset out of the array.
    stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_stack_ram (
        .CLK   (CLK),
        .we    (ramWe & ~reset),
        .waddr (ramWaddr),
        .wdata (bus.WriteDataM),
        .raddr (topIdx),
        .rdata (ramRdata)
    );

    assign bus.ReadDataM  = bus.MemSrcM ? stackView : bus.DataMemRD;
    assign bus.SP         = sp;
    assign bus.StackFull  = full;
    assign bus.StackEmpty = empty;
    assign bus.StackOvf   = ovf;
    assign bus.StackUnf   = unf;

endmodule

// File: tb/tb_mem_stack_unit.sv
// Directed bench for mem_stack_unit at DEPTH=4 with hand-computed expectations.
module tb_mem_stack_unit;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic CLK;
    logic reset;
    int   checksRun;
    int   checksPassed;

    mem_stack_unit_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    mem_stack_unit #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksRun++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic push, input logic pop, input logic src,
                         input logic [31:0] wd, input logic [31:0] dm, input logic clr);
        bus.PushM      = push;
        bus.PopM       = pop;
        bus.MemSrcM    = src;
        bus.WriteDataM = wd;
        bus.DataMemRD  = dm;
        bus.ErrClr     = clr;
        #1;
    endtask

    // Cross one rising edge and settle on the following falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic pushVal(input logic [31:0] v);
        drive(1'b1, 1'b0, 1'b1, v, 32'h0, 1'b0);
        tick();
    endtask

    task automatic checkStatus(input string tag, input logic [31:0] sp,
                               input logic full, input logic empty,
                               input logic ovf, input logic unf);
        checkEq({tag, ".SP"},    32'(bus.SP),     sp);
        checkEq({tag, ".full"},  32'(bus.StackFull),  32'(full));
        checkEq({tag, ".empty"}, 32'(bus.StackEmpty), 32'(empty));
        checkEq({tag, ".ovf"},   32'(bus.StackOvf),   32'(ovf));
        checkEq({tag, ".unf"},   32'(bus.StackUnf),   32'(unf));
    endtask

    initial begin
        checksRun    = 0;
        checksPassed = 0;
        reset        = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0);

        // Reset state and read mux while held in reset
        checkStatus("rst", 0, 0, 1, 0, 0);
        checkEq("rst.dmem", bus.ReadDataM, 32'h1234_5678);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0);
        checkEq("rst.stackView", bus.ReadDataM, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h5A, 32'h0, 1'b0);
        checkEq("rst.bypass", bus.ReadDataM, 32'h5A);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        idle();

        // Three pushes, then idle top-of-stack view
        pushVal(32'h11);
        pushVal(32'h22);
        pushVal(32'h33);
        idle();
        checkStatus("push3", 3, 0, 0, 0, 0);
        checkEq("push3.top", bus.ReadDataM, 32'h33);

        // Fill, overflow, clear, then set-dominant clear
        pushVal(32'h44);
        idle();
        checkStatus("fill", 4, 1, 0, 0, 0);
        pushVal(32'h55);
        idle();
        checkStatus("ovf", 4, 1, 0, 1, 0);
        checkEq("ovf.top", bus.ReadDataM, 32'h44);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        tick();
        idle();
        checkEq("ovf.cleared", 32'(bus.StackOvf), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h66, 32'h0, 1'b1);
        tick();
        idle();
        checkEq("ovf.setDominant", 32'(bus.StackOvf), 32'h1);
        checkEq("ovf.topKept", bus.ReadDataM, 32'h44);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        tick();

        // Drain with same-cycle pop views
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        checkEq("pop.v44", bus.ReadDataM, 32'h44);
        tick();
        checkEq("pop.v33", bus.ReadDataM, 32'h33);
        tick();
        checkEq("pop.v22", bus.ReadDataM, 32'h22);
        tick();
        checkEq("pop.v11", bus.ReadDataM, 32'h11);
        tick();
        idle();
        checkStatus("drained", 0, 0, 1, 0, 0);

        // Underflow, then empty push+pop bypass
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        checkEq("unf.view", bus.ReadDataM, 32'h0);
        tick();
        idle();
        checkStatus("unf", 0, 0, 1, 0, 1);
        drive(1'b1, 1'b1, 1'b1, 32'hAB, 32'h0, 1'b0);
        checkEq("bypass.view", bus.ReadDataM, 32'hAB);
        tick();
        idle();
        checkStatus("bypass", 0, 0, 1, 0, 1);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        tick();
        idle();
        checkEq("unf.cleared", 32'(bus.StackUnf), 32'h0);

        // Replace top on {0x11, 0x22}
        pushVal(32'h11);
        pushVal(32'h22);
        drive(1'b1, 1'b1, 1'b1, 32'h99, 32'h0, 1'b0);
        checkEq("replace.view", bus.ReadDataM, 32'h22);
        tick();
        idle();
        checkStatus("replace", 2, 0, 0, 0, 0);
        checkEq("replace.top", bus.ReadDataM, 32'h99);

        // Data-memory passthrough with an independent pop
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        checkEq("dmem.view", bus.ReadDataM, 32'hDEAD_BEEF);
        tick();
        idle();
        checkEq("dmem.SP", 32'(bus.SP), 32'd1);
        checkEq("dmem.top", bus.ReadDataM, 32'h11);

        // Build SP=2 with unf set, then reset between the edges of a push
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        pushVal(32'h11);
        pushVal(32'h22);
        idle();
        checkStatus("preRst", 2, 0, 0, 0, 1);
        drive(1'b1, 1'b0, 1'b1, 32'h77, 32'h0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        checkStatus("midRst", 0, 0, 1, 0, 0);
        @(negedge CLK);
        reset = 1'b0;
        idle();
        checkStatus("postRst", 0, 0, 1, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        checkEq("postRst.popView", bus.ReadDataM, 32'h0);
        tick();
        idle();
        checkStatus("postRst.pop", 0, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
